// File: rtl/banked_mem_responder_pkg.sv
// Shared definitions for the banked memory responder and the controller-side checker.
package banked_mem_responder_pkg;

  localparam int NUM_BANKS    = 4;
  localparam int BANK_SEL_LSB = 1;
  localparam int BANK_SEL_MSB = 2;
  localparam int RD_LAT       = 2;
  localparam int DATA_W       = 16;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_READ,
    REQ_WRITE,
    REQ_ILLEGAL
  } req_type_e;

  // Both strobes at once, or any request on an odd byte address, is illegal.
  function automatic req_type_e classify_req(input logic rd, input logic wr, input logic a0);
    if (rd && wr)         return REQ_ILLEGAL;
    if ((rd || wr) && a0) return REQ_ILLEGAL;
    if (rd)               return REQ_READ;
    if (wr)               return REQ_WRITE;
    return REQ_IDLE;
  endfunction

endpackage

// File: rtl/banked_mem_responder_bank_busy_counter.sv
// Per-bank occupancy counter: loaded on accept, counts down to idle.
module bank_busy_counter #(
  parameter int BANK_BUSY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  logic [3:0] cnt_q, cnt_d;

  // Load the occupancy window on accept, otherwise drain towards zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = 4'(BANK_BUSY - 1);
    else if (cnt_q != '0)  cnt_d = cnt_q - 4'd1;
  end

  // Counter state; reset frees the bank immediately.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // The accept cycle itself is not flagged busy; the loaded count covers the rest.
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved memory responder with fixed 2-cycle read return.
module banked_mem_responder
  import banked_mem_responder_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BANK_BUSY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int WORD_W = ADDR_W - 1;
  localparam int WORDS  = 1 << WORD_W;

  logic [DATA_W-1:0]              mem_q [WORDS];
  req_type_e                      req_type;
  logic [1:0]                     bank;
  logic [WORD_W-1:0]              word;
  logic                           legal_req;
  logic                           accept;
  logic                           rd_acc;
  logic                           wr_acc;
  logic [NUM_BANKS-1:0]           load;
  logic [RD_LAT-1:0]              rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0][DATA_W-1:0]  rd_data_q, rd_data_d;

  // Classify the request and decide accept/stall/err; nothing is accepted while in reset.
  always_comb begin
    req_type  = classify_req(rd, wr, addr[0]);
    bank      = addr[BANK_SEL_MSB:BANK_SEL_LSB];
    word      = addr[ADDR_W-1:1];
    legal_req = (req_type == REQ_READ) || (req_type == REQ_WRITE);
    err       = (req_type == REQ_ILLEGAL);
    stall     = legal_req && busy[bank];
    accept    = legal_req && !busy[bank] && !rst;
    rd_acc    = accept && (req_type == REQ_READ);
    wr_acc    = accept && (req_type == REQ_WRITE);
    load      = '0;
    if (accept) load[bank] = 1'b1;
  end

  bank_busy_counter #(.BANK_BUSY(BANK_BUSY)) u_bank_cnt [NUM_BANKS-1:0] (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .busy (busy)
  );

  // Read return pipe: stage 0 samples the word at acceptance, later stages just shift.
  always_comb begin
    rd_vld_d[0]  = rd_acc;
    rd_data_d[0] = mem_q[word];
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_data_d[i] = rd_data_q[i-1];
    end
  end

  // Valid bits are reset so in-flight reads vanish; data words need no reset.
  always_ff @(posedge clk) begin
    if (rst) rd_vld_q <= '0;
    else     rd_vld_q <= rd_vld_d;
    rd_data_q <= rd_data_d;
  end

  // Backing store; a same-edge read of the same word is impossible since the bank is busy.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[word] <= data_in;
  end

  assign data_out = rd_vld_q[RD_LAT-1] ? rd_data_q[RD_LAT-1] : '0;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Bench for banked_mem_responder: timeline reference model plus directed literal checks.
module tb_banked_mem_responder;

  localparam int BB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, data_in = '0;
  logic [15:0] data_out;
  logic        stall, err;
  logic [3:0]  busy;

  banked_mem_responder #(.ADDR_W(16), .BANK_BUSY(BB)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out), .stall(stall), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remembers the cycle each bank last accepted and when read data is due.
  logic [15:0] mmem   [int];
  logic [16:0] exp_rd [int];
  int          acc_cyc [4] = '{default: -1000};
  int          mc = 0;

  always @(negedge clk) begin
    logic       req, ill;
    int         b, w;
    logic [3:0] eb;
    logic [15:0] ed;
    logic       dknown;
    req = rd | wr;
    ill = (rd & wr) | (req & addr[0]);
    b   = int'(addr[2:1]);
    w   = int'(addr[15:1]);
    for (int i = 0; i < 4; i++) eb[i] = (mc > acc_cyc[i]) && (mc < acc_cyc[i] + BB);
    if (exp_rd.exists(mc)) begin
      ed = exp_rd[mc][15:0]; dknown = exp_rd[mc][16]; exp_rd.delete(mc);
    end else begin
      ed = '0; dknown = 1'b1;
    end
    if (chk_en) begin
      check("m_err", err, ill);
      check("m_stall", stall, req & ~ill & eb[b]);
      check("m_busy", busy, eb);
      if (dknown) check("m_data", data_out, ed);
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) acc_cyc[i] = -1000;
      if (exp_rd.exists(mc + 1)) exp_rd.delete(mc + 1);
      if (exp_rd.exists(mc + 2)) exp_rd.delete(mc + 2);
    end else if (req && !ill && !eb[b]) begin
      acc_cyc[b] = mc;
      if (wr) mmem[w] = data_in;
      else    exp_rd[mc + 2] = mmem.exists(w) ? {1'b1, mmem[w]} : 17'h0;
    end
    mc++;
  end

  task automatic drive(input logic r, input logic rdi, input logic wri,
                       input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    rst = r; rd = rdi; wr = wri; addr = a; data_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  logic [3:0]  busy_tab [7] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
  logic [15:0] d2_tab   [7] = '{16'h0, 16'h0, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'h0};
  logic        st3_tab  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] d3_tab   [7] = '{16'h0, 16'h0, 16'hA008, 16'h0, 16'h0, 16'h0, 16'hA00C};

  initial begin
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 4'h0);
    check("rst_data", data_out, 16'h0);
    check("rst_stall", stall, 1'b0);
    check("rst_err", err, 1'b0);

    // Preload words 0..31 with A000|i; rotating banks never stall.
    for (int i = 0; i < 32; i++) drive(1'b0, 1'b0, 1'b1, 16'(i * 2), 16'hA000 | 16'(i));
    idle(4);

    // Write then read back one word.
    drive(1'b0, 1'b0, 1'b1, 16'h0008, 16'hBEEF);
    idle(4);
    drive(1'b0, 1'b1, 1'b0, 16'h0008, 16'h0);
    @(negedge clk); check("t1_err", err, 1'b0); check("t1_stall", stall, 1'b0);
    idle(1); @(negedge clk); check("t1_d1", data_out, 16'h0);
    idle(1); @(negedge clk); check("t1_d2", data_out, 16'hBEEF);
    idle(1); @(negedge clk); check("t1_d3", data_out, 16'h0);
    idle(2);

    // Fill sequence across all four banks.
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b0, 1'b1, 1'b0, 16'(i * 2), 16'h0);
      else       idle(1);
      @(negedge clk);
      check("t2_busy", busy, busy_tab[i]);
      check("t2_data", data_out, d2_tab[i]);
      check("t2_stall", stall, 1'b0);
    end
    idle(4);

    // Same-bank conflict: three stalled retries, fourth accepted.
    for (int i = 0; i < 7; i++) begin
      if (i == 0)     drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
      else if (i < 5) drive(1'b0, 1'b1, 1'b0, 16'h0018, 16'h0);
      else            idle(1);
      @(negedge clk);
      check("t3_stall", stall, st3_tab[i]);
      check("t3_data", data_out, d3_tab[i]);
    end
    idle(4);

    // Illegal requests: flagged, no side effects.
    drive(1'b0, 1'b1, 1'b1, 16'h000A, 16'h1234);
    @(negedge clk); check("t4_err_rw", err, 1'b1); check("t4_stall_rw", stall, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0);
    @(negedge clk); check("t4_err_odd", err, 1'b1); check("t4_busy1", busy, 4'h0);
    check("t4_data1", data_out, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 16'h000B, 16'h1111);
    @(negedge clk); check("t4_err_wodd", err, 1'b1); check("t4_data2", data_out, 16'h0);
    idle(1); @(negedge clk); check("t4_data3", data_out, 16'h0); check("t4_busy2", busy, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h000A, 16'h0);
    idle(2); @(negedge clk); check("t4_readback", data_out, 16'hA005);
    idle(2);

    // Reset during an in-flight read.
    drive(1'b0, 1'b1, 1'b0, 16'h000C, 16'h0);
    @(negedge clk); check("t5_stall", stall, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk); check("t5_busy_inrst", busy, 4'h4);
    idle(1); @(negedge clk); check("t5_data", data_out, 16'h0); check("t5_busy", busy, 4'h0);
    idle(1); @(negedge clk); check("t5_data2", data_out, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0008, 16'h0);
    idle(2); @(negedge clk); check("t5_keep", data_out, 16'hBEEF);
    idle(2);

    // Mixed traffic across banks 1, 2, 3.
    drive(1'b0, 1'b0, 1'b1, 16'h0012, 16'h5A5A);
    @(negedge clk); check("t6_stall0", stall, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'h0014, 16'h0);
    @(negedge clk); check("t6_stall1", stall, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'h0016, 16'h7777);
    @(negedge clk); check("t6_stall2", stall, 1'b0);
    idle(1); @(negedge clk); check("t6_rdata", data_out, 16'hA00A);
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 16'h0012, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0016, 16'h0);
    idle(1); @(negedge clk); check("t6_wb1", data_out, 16'h5A5A);
    idle(1); @(negedge clk); check("t6_wb3", data_out, 16'h7777);
    idle(2);

    // Random traffic checked only by the model.
    repeat (800) begin
      int k;
      logic r;
      k = int'($urandom_range(0, 7));
      r = ($urandom_range(0, 99) == 0);
      drive(r, (k <= 2) || (k == 6), (k >= 3 && k <= 5) || (k == 6),
            16'($urandom_range(0, 63)), 16'($urandom));
    end
    idle(4);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
